// File: rtl/hazard_stall_control_pkg.sv
// Shared processor definitions: instruction field positions, opcodes, ALU ops,
// multdiv FSM encoding and the default multdiv timeout.
package hazard_stall_control_pkg;

    localparam int IR_W  = 32;
    localparam int OP_W  = 5;
    localparam int REG_W = 5;
    localparam int CNT_W = 6;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 27;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;
    localparam int RS_HI  = 21;
    localparam int RS_LO  = 17;
    localparam int RT_HI  = 16;
    localparam int RT_LO  = 12;
    localparam int ALU_HI = 6;
    localparam int ALU_LO = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 5'd0;
    localparam logic [OP_W-1:0] OP_ADDI  = 5'd5;
    localparam logic [OP_W-1:0] OP_SW    = 5'd7;
    localparam logic [OP_W-1:0] OP_LW    = 5'd8;

    localparam logic [OP_W-1:0] ALU_MUL = 5'd6;
    localparam logic [OP_W-1:0] ALU_DIV = 5'd7;

    localparam int MD_TIMEOUT_DEFAULT = 63;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_mul_div(input logic [OP_W-1:0] op,
                                        input logic [OP_W-1:0] aluop);
        return (op == OP_RTYPE) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
    endfunction

endpackage

// File: rtl/hazard_stall_control_load_use_detect.sv
// Combinational load-use detector: flags when the instruction in F/D reads an
// address/ALU source written by a load sitting in D/X.
module load_use_detect
    import hazard_stall_control_pkg::*;
(
    input  logic [IR_W-1:0] FDIR,
    input  logic [IR_W-1:0] DXIR,
    output logic            hazard
);

    logic [OP_W-1:0]  fd_op;
    logic [OP_W-1:0]  dx_op;
    logic [REG_W-1:0] fd_rs;
    logic [REG_W-1:0] fd_rt;
    logic [REG_W-1:0] dx_rd;
    logic             reads_rs;
    logic             reads_rt;
    logic             unused_fields;

    assign fd_op = FDIR[OP_HI:OP_LO];
    assign fd_rs = FDIR[RS_HI:RS_LO];
    assign fd_rt = FDIR[RT_HI:RT_LO];
    assign dx_op = DXIR[OP_HI:OP_LO];
    assign dx_rd = DXIR[RD_HI:RD_LO];

    // A store's data register (rd) is bypassed from memory, so only rs counts for sw.
    assign reads_rs = (fd_op == OP_RTYPE) || (fd_op == OP_ADDI) ||
                      (fd_op == OP_SW)    || (fd_op == OP_LW);
    assign reads_rt = (fd_op == OP_RTYPE);

    assign hazard = (dx_op == OP_LW) && (dx_rd != '0) &&
                    ((reads_rs && (fd_rs == dx_rd)) || (reads_rt && (fd_rt == dx_rd)));

    assign unused_fields = ^{FDIR[RD_HI:RD_LO], FDIR[RT_LO-1:0], DXIR[RD_LO-1:0]};

endmodule

// File: rtl/hazard_stall_control.sv
// Pipeline hazard and stall controller: load-use stalls, branch flushes and
// the multdiv start/wait/timeout sequencer holding the D/X instruction.
module hazard_stall_control
    import hazard_stall_control_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEFAULT
)
(
    input  logic            clock,
    input  logic            reset,
    input  logic [IR_W-1:0] FDIR,
    input  logic [IR_W-1:0] DXIR,
    input  logic            branch_taken,
    input  logic            md_ready,
    output logic            pc_enable,
    output logic            fd_enable,
    output logic            dx_enable,
    output logic            dx_flush,
    output logic            xm_bubble,
    output logic            fd_flush,
    output logic            md_start_mult,
    output logic            md_start_div,
    output logic            md_timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    md_state_e        state;
    md_state_e        state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             load_use;
    logic             dx_md;
    logic [OP_W-1:0]  dx_op;
    logic [OP_W-1:0]  dx_aluop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    load_use_detect u_load_use (
        .FDIR   (FDIR),
        .DXIR   (DXIR),
        .hazard (load_use)
    );

    assign dx_op    = DXIR[OP_HI:OP_LO];
    assign dx_aluop = DXIR[ALU_HI:ALU_LO];
    assign dx_md    = is_mul_div(dx_op, dx_aluop);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= MD_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // md_ready only steers BUSY, so it never reaches the start pulses.
    always_comb begin
        state_next    = state;
        count_next    = count;
        pc_enable     = 1'b1;
        fd_enable     = 1'b1;
        dx_enable     = 1'b1;
        dx_flush      = 1'b0;
        xm_bubble     = 1'b0;
        fd_flush      = 1'b0;
        md_start_mult = 1'b0;
        md_start_div  = 1'b0;
        md_timeout    = 1'b0;
        if (!reset) begin
            case (state)
                MD_IDLE: begin
                    if (branch_taken) begin
                        fd_flush = 1'b1;
                        dx_flush = 1'b1;
                    end else if (dx_md) begin
                        md_start_mult = (dx_aluop == ALU_MUL);
                        md_start_div  = (dx_aluop == ALU_DIV);
                        pc_enable     = 1'b0;
                        fd_enable     = 1'b0;
                        dx_enable     = 1'b0;
                        xm_bubble     = 1'b1;
                        count_next    = '0;
                        state_next    = MD_BUSY;
                    end else if (load_use) begin
                        pc_enable = 1'b0;
                        fd_enable = 1'b0;
                        dx_flush  = 1'b1;
                    end
                end
                MD_BUSY: begin
                    pc_enable  = 1'b0;
                    fd_enable  = 1'b0;
                    dx_enable  = 1'b0;
                    xm_bubble  = 1'b1;
                    count_next = sat_inc(count);
                    if (md_ready) begin
                        state_next = MD_DONE;
                    end else if (count == CNT_LAST) begin
                        md_timeout = 1'b1;
                        state_next = MD_DONE;
                    end
                end
                MD_DONE: begin
                    state_next = MD_IDLE;
                    if (branch_taken) begin
                        fd_flush = 1'b1;
                        dx_flush = 1'b1;
                    end else if (load_use) begin
                        pc_enable = 1'b0;
                        fd_enable = 1'b0;
                        dx_flush  = 1'b1;
                    end
                end
                default: state_next = MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_control.sv
// Directed and randomized bench for hazard_stall_control against a
// cycle-count reference model of the stall/flush rules.
module tb_hazard_stall_control;

    localparam int TIMEOUT = 63;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] FDIR = '0;
    logic [31:0] DXIR = '0;
    logic        branch_taken = 1'b0;
    logic        md_ready = 1'b0;
    logic        pc_enable, fd_enable, dx_enable, dx_flush, xm_bubble, fd_flush;
    logic        md_start_mult, md_start_div, md_timeout;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: m_age = index of the current BUSY cycle (0 = nothing in flight),
    // m_fin = the operation finished and this cycle lets it leave D/X.
    int m_age = 0;
    bit m_fin = 0;

    always #5 clock = ~clock;

    hazard_stall_control dut (
        .clock         (clock),
        .reset         (reset),
        .FDIR          (FDIR),
        .DXIR          (DXIR),
        .branch_taken  (branch_taken),
        .md_ready      (md_ready),
        .pc_enable     (pc_enable),
        .fd_enable     (fd_enable),
        .dx_enable     (dx_enable),
        .dx_flush      (dx_flush),
        .xm_bubble     (xm_bubble),
        .fd_flush      (fd_flush),
        .md_start_mult (md_start_mult),
        .md_start_div  (md_start_div),
        .md_timeout    (md_timeout)
    );

    function automatic logic [31:0] rtype(int rd, int rs, int rt, int aluop);
        return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(aluop), 2'b00};
    endfunction

    function automatic logic [31:0] itype(int op, int rd, int rs, int imm);
        return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
    endfunction

    function automatic bit ref_load_use(logic [31:0] fd, logic [31:0] dx);
        int fop = int'(fd[31:27]);
        int dop = int'(dx[31:27]);
        int drd = int'(dx[26:22]);
        bit reads_rs = (fop == 0) || (fop == 5) || (fop == 7) || (fop == 8);
        bit reads_rt = (fop == 0);
        if (dop != 8 || drd == 0) return 0;
        return (reads_rs && int'(fd[21:17]) == drd) || (reads_rt && int'(fd[16:12]) == drd);
    endfunction

    function automatic logic [31:0] rand_ir();
        int ops[5];
        int alus[4];
        ops  = '{0, 5, 7, 8, int'($urandom_range(0, 31))};
        alus = '{0, 6, 7, int'($urandom_range(0, 31))};
        return {5'(ops[$urandom_range(0, 4)]), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 31)), 5'(alus[$urandom_range(0, 3)]), 2'b00};
    endfunction

    task automatic cycle(input string tag, input logic rst, input logic [31:0] fd,
                         input logic [31:0] dx, input logic bt, input logic rdy);
        bit e_pc = 1, e_fd = 1, e_dx = 1, e_dxf = 0, e_xmb = 0, e_fdf = 0;
        bit e_sm = 0, e_sd = 0, e_to = 0;
        bit dx_is_md;
        logic [8:0] exp_v, obs_v;
        reset = rst; FDIR = fd; DXIR = dx; branch_taken = bt; md_ready = rdy;
        @(negedge clock);
        dx_is_md = (dx[31:27] == 0) && (dx[6:2] == 6 || dx[6:2] == 7);
        if (rst) begin
            m_age = 0; m_fin = 0;
        end else if (m_fin || m_age == 0) begin
            if (bt) begin
                e_fdf = 1; e_dxf = 1;
            end else if (!m_fin && dx_is_md) begin
                e_sm = (dx[6:2] == 6); e_sd = (dx[6:2] == 7);
                e_pc = 0; e_fd = 0; e_dx = 0; e_xmb = 1;
                m_age = 1;
            end else if (ref_load_use(fd, dx)) begin
                e_pc = 0; e_fd = 0; e_dxf = 1;
            end
            m_fin = 0;
        end else begin
            e_pc = 0; e_fd = 0; e_dx = 0; e_xmb = 1;
            if (rdy) begin
                m_fin = 1; m_age = 0;
            end else if (m_age == TIMEOUT) begin
                e_to = 1; m_fin = 1; m_age = 0;
            end else begin
                m_age++;
            end
        end
        exp_v = {e_pc, e_fd, e_dx, e_dxf, e_xmb, e_fdf, e_sm, e_sd, e_to};
        obs_v = {pc_enable, fd_enable, dx_enable, dx_flush, xm_bubble, fd_flush,
                 md_start_mult, md_start_div, md_timeout};
        n_assert++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (pc,fd,dx,dxf,xmb,fdf,sm,sd,to)",
                   tag, obs_v, exp_v);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] nop, lw_r3, lw_r0, mul, dv;
        nop   = 32'd0;
        lw_r3 = itype(8, 3, 1, 0);
        lw_r0 = itype(8, 0, 1, 0);
        mul   = rtype(2, 3, 4, 6);
        dv    = rtype(5, 6, 7, 7);

        cycle("reset_0", 1, rtype(4, 3, 5, 0), lw_r3, 0, 0);
        cycle("reset_md_branch", 1, nop, mul, 1, 1);

        cycle("lu_add_stall", 0, rtype(4, 3, 5, 0), lw_r3, 0, 0);
        cycle("lu_add_release", 0, rtype(4, 3, 5, 0), nop, 0, 0);
        cycle("lu_sw_data", 0, itype(7, 3, 6, 0), lw_r3, 0, 0);
        cycle("lu_sw_base", 0, itype(7, 7, 3, 0), lw_r3, 0, 0);
        cycle("lu_r0", 0, rtype(4, 0, 0, 0), lw_r0, 0, 0);
        cycle("lu_add_rt", 0, rtype(4, 5, 3, 0), lw_r3, 0, 0);
        cycle("lu_addi_rs", 0, itype(5, 4, 3, 1), lw_r3, 0, 0);
        cycle("lu_addi_rt_only", 0, itype(5, 4, 1, 32'h3000), lw_r3, 0, 0);
        cycle("lu_lw_rs", 0, itype(8, 4, 3, 0), lw_r3, 0, 0);
        cycle("lu_branch_override", 0, rtype(4, 3, 5, 0), lw_r3, 1, 0);

        cycle("mul_start", 0, nop, mul, 0, 1);
        for (int i = 1; i <= 4; i++) cycle("mul_busy", 0, nop, mul, (i == 2), 0);
        cycle("mul_busy5_ready", 0, nop, mul, 0, 1);
        cycle("mul_done", 0, rtype(4, 3, 5, 0), mul, 0, 1);
        cycle("mul_after", 0, nop, nop, 0, 1);

        cycle("div_start", 0, nop, dv, 0, 0);
        for (int i = 1; i <= TIMEOUT; i++) cycle("div_busy", 0, nop, dv, 0, 0);
        cycle("div_done", 0, nop, dv, 0, 1);
        cycle("div_idle", 0, nop, nop, 0, 0);

        cycle("rst_busy_start", 0, nop, mul, 0, 0);
        cycle("rst_busy_1", 0, nop, mul, 0, 0);
        cycle("rst_busy_2", 0, nop, mul, 0, 0);
        cycle("rst_busy_3", 1, nop, mul, 0, 0);
        cycle("rst_idle", 0, nop, nop, 0, 1);
        cycle("branch_mul", 0, nop, mul, 1, 0);
        cycle("branch_after", 0, nop, nop, 0, 0);
        cycle("done_branch_start", 0, nop, dv, 0, 0);
        cycle("done_branch_busy", 0, nop, dv, 0, 1);
        cycle("done_branch", 0, rtype(4, 3, 5, 0), dv, 1, 0);

        for (int i = 0; i < 600; i++) begin
            cycle("random", ($urandom_range(0, 49) == 0), rand_ir(), rand_ir(),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
